// File: rtl/mips_lsu.sv
// mips_lsu: load/store unit with req/ack memory handshake, lane masking and load extension.
// Define MIPS_LSU_TIMEOUT_EN to force a bus error after TIMEOUT_CYCLES cycles in WAIT.
module mips_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_signed,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic [31:0] lsu_rdata,
  output logic        lsu_done,
  output logic        lsu_stall,
  output logic        lsu_excpt,
  output logic [1:0]  lsu_excpt_code,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [3:0]  mem_write_en,
  output logic        mem_req,
  input  logic [31:0] mem_data_out,
  input  logic        mem_ack,
  input  logic        mem_excpt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] C_ADEL = 2'b01;
  localparam logic [1:0] C_ADES = 2'b10;
  localparam logic [1:0] C_DBE  = 2'b11;

  if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
    $error("mips_lsu: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  logic [1:0]  r_state;
  logic [1:0]  r_size;
  logic [1:0]  r_code;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_wen;

  logic        w_idle;
  logic        w_wait;
  logic        w_misal;
  logic        w_timeout;
  logic [3:0]  w_mask;
  logic [31:0] w_rep;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_idle = (r_state == S_IDLE);
  assign w_wait = (r_state == S_WAIT);

  always_comb begin
    w_misal = 1'b0;
    w_mask  = 4'b1111;
    w_rep   = lsu_wdata;
    case (lsu_size)
      2'b00: begin
        w_mask = 4'b0001 << lsu_addr[1:0];
        w_rep  = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        w_misal = lsu_addr[0];
        w_mask  = 4'b0011 << lsu_addr[1:0];
        w_rep   = {2{lsu_wdata[15:0]}};
      end
      default: w_misal = |lsu_addr[1:0];
    endcase
  end

  always_comb begin
    w_byte = mem_data_out[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = mem_data_out[15:8];
      2'd2:    w_byte = mem_data_out[23:16];
      2'd3:    w_byte = mem_data_out[31:24];
      default: w_byte = mem_data_out[7:0];
    endcase
    w_half = r_addr[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ext = mem_data_out;
    endcase
  end

`ifdef MIPS_LSU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (w_idle && lsu_req) begin
      r_cnt <= '0;
    end else if (w_wait && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = w_wait && (r_cnt >= TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state  <= S_IDLE;
      r_size   <= 2'b00;
      r_code   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_wen    <= 4'b0000;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (lsu_req && w_misal) begin
            r_code  <= lsu_we ? C_ADES : C_ADEL;
            r_state <= S_ERR;
          end else if (lsu_req) begin
            r_size   <= lsu_size;
            r_signed <= lsu_signed;
            r_addr   <= lsu_addr;
            r_wdata  <= w_rep;
            r_wen    <= lsu_we ? w_mask : 4'b0000;
            r_state  <= S_WAIT;
          end
        end
        // bus error beats ack; ack beats a coincident timeout
        S_WAIT: begin
          if (mem_excpt) begin
            r_code  <= C_DBE;
            r_state <= S_ERR;
          end else if (mem_ack) begin
            r_rdata <= w_ext;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_code  <= C_DBE;
            r_state <= S_ERR;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req        = w_wait;
  assign mem_addr       = r_addr[31:2];
  assign mem_data_in    = r_wdata;
  assign mem_write_en   = w_wait ? r_wen : 4'b0000;
  assign lsu_done       = (r_state == S_DONE);
  assign lsu_excpt      = (r_state == S_ERR);
  assign lsu_excpt_code = lsu_excpt ? r_code : 2'b00;
  assign lsu_rdata      = r_rdata;
  assign lsu_stall      = (rst_b & w_idle & lsu_req) | w_wait;

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: directed vectors with queue scoreboards for memory-side and retire-side events.
// Timeout vector is built only with MIPS_LSU_TIMEOUT_EN (bench overrides TIMEOUT_CYCLES=4).
module tb_mips_lsu;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [1:0]  lsu_size = 2'b00;
  logic        lsu_signed = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_stall;
  logic        lsu_excpt;
  logic [1:0]  lsu_excpt_code;
  logic [29:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_write_en;
  logic        mem_req;
  logic [31:0] mem_data_out = '0;
  logic        mem_ack = 1'b0;
  logic        mem_excpt = 1'b0;

  mips_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_b(rst_b),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_signed(lsu_signed), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_stall(lsu_stall),
    .lsu_excpt(lsu_excpt), .lsu_excpt_code(lsu_excpt_code),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .mem_req(mem_req),
    .mem_data_out(mem_data_out), .mem_ack(mem_ack), .mem_excpt(mem_excpt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  wen;
    logic [31:0] din;
  } mem_exp_t;

  typedef struct {
    logic        excpt;
    logic [1:0]  code;
    logic        chk;
    logic [31:0] data;
    int          cyc;
  } ret_exp_t;

  mem_exp_t mq[$];
  ret_exp_t rq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic prev_req = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    mem_exp_t m;
    if (mem_req && !prev_req) begin
      if (mq.size() == 0) begin
        chk("unexpected_mem_req", 32'(mem_req), 32'd0);
      end else begin
        m = mq.pop_front();
        chk("mem_addr", {2'b00, mem_addr}, {2'b00, m.addr});
        chk("mem_write_en", {28'd0, mem_write_en}, {28'd0, m.wen});
        chk("mem_data_in", mem_data_in, m.din);
      end
    end
    prev_req = mem_req;
  end

  always @(negedge clk) begin
    ret_exp_t e;
    if (lsu_done || lsu_excpt) begin
      if (rq.size() == 0) begin
        chk("unexpected_retire", {30'd0, lsu_done, lsu_excpt}, 32'd0);
      end else begin
        e = rq.pop_front();
        chk("retire_cycle", cyc, e.cyc);
        chk("done", 32'(lsu_done), 32'(!e.excpt));
        chk("excpt", 32'(lsu_excpt), 32'(e.excpt));
        if (e.excpt) chk("excpt_code", 32'(lsu_excpt_code), 32'(e.code));
        if (e.chk) chk("lsu_rdata", lsu_rdata, e.data);
      end
    end
  end

  task automatic run(
    input logic we, input logic [1:0] sz, input logic sg,
    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
    input int lat, input logic ack, input logic ex,
    input logic [29:0] e_maddr, input logic [3:0] e_wen, input logic [31:0] e_din,
    input logic misal, input logic e_excpt, input logic [1:0] e_code,
    input logic e_chk, input logic [31:0] e_rd);
    ret_exp_t r;
    mem_exp_t m;
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = we; lsu_size = sz; lsu_signed = sg;
    lsu_addr = a; lsu_wdata = wd;
    r.excpt = e_excpt; r.code = e_code; r.chk = e_chk; r.data = e_rd;
    r.cyc = misal ? cyc + 1 : cyc + 1 + lat;
    rq.push_back(r);
    if (!misal) begin
      m.addr = e_maddr; m.wen = e_wen; m.din = e_din;
      mq.push_back(m);
    end
    @(negedge clk);
    chk("stall_req_cycle", 32'(lsu_stall), 32'd1);
    chk("no_mem_req_idle", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    if (!misal) begin
      for (int i = 1; i <= lat; i++) begin
        if (i == lat) begin
          mem_ack = ack; mem_excpt = ex; mem_data_out = rd;
        end
        @(negedge clk);
        chk("stall_wait", 32'(lsu_stall), 32'd1);
        chk("mem_req_wait", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
      end
    end
    lsu_req = 1'b0; mem_ack = 1'b0; mem_excpt = 1'b0;
    @(negedge clk);
    chk("stall_retire", 32'(lsu_stall), 32'd0);
    chk("mem_req_retire", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pulse_one_cycle", {30'd0, lsu_done, lsu_excpt}, 32'd0);
  endtask

  initial begin
    mem_exp_t m;
    #2;
    chk("rst_outputs", {lsu_rdata}, 32'd0);
    chk("rst_ctrl", {28'd0, lsu_done, lsu_stall, lsu_excpt, mem_req}, 32'd0);
    chk("rst_mem", {2'b00, mem_addr} | mem_data_in | {28'd0, mem_write_en}, 32'd0);
    chk("rst_code", 32'(lsu_excpt_code), 32'd0);
    #20; rst_b = 1'b1;

    // word store, minimum latency
    run(1, 2'b10, 0, 32'h1000_0008, 32'hDEAD_BEEF, 0, 1, 1, 0,
        30'h0400_0002, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    // byte/half/word loads from 0x807F0000
    run(0, 2'b00, 1, 32'h103, 0, 32'h807F_0000, 1, 1, 0,
        30'h40, 4'b0000, 32'h0, 0, 0, 0, 1, 32'hFFFF_FF80);
    run(0, 2'b00, 0, 32'h103, 0, 32'h807F_0000, 1, 1, 0,
        30'h40, 4'b0000, 32'h0, 0, 0, 0, 1, 32'h0000_0080);
    run(0, 2'b00, 1, 32'h102, 0, 32'h807F_0000, 1, 1, 0,
        30'h40, 4'b0000, 32'h0, 0, 0, 0, 1, 32'h0000_007F);
    run(0, 2'b01, 1, 32'h102, 0, 32'h807F_0000, 1, 1, 0,
        30'h40, 4'b0000, 32'h0, 0, 0, 0, 1, 32'hFFFF_807F);
    run(0, 2'b01, 0, 32'h100, 0, 32'h807F_0000, 2, 1, 0,
        30'h40, 4'b0000, 32'h0, 0, 0, 0, 1, 32'h0000_0000);
    run(0, 2'b10, 1, 32'h100, 0, 32'h807F_0000, 1, 1, 0,
        30'h40, 4'b0000, 32'h0, 0, 0, 0, 1, 32'h807F_0000);
    // sub-word and reserved-size stores
    run(1, 2'b01, 0, 32'h2002, 32'h0000_1234, 0, 1, 1, 0,
        30'h800, 4'b1100, 32'h1234_1234, 0, 0, 0, 0, 0);
    run(1, 2'b00, 0, 32'h2001, 32'h0000_00AB, 0, 1, 1, 0,
        30'h800, 4'b0010, 32'hABAB_ABAB, 0, 0, 0, 0, 0);
    run(1, 2'b00, 0, 32'h0003, 32'h0000_005A, 0, 2, 1, 0,
        30'h0, 4'b1000, 32'h5A5A_5A5A, 0, 0, 0, 0, 0);
    run(1, 2'b11, 0, 32'h040C, 32'h5566_7788, 0, 1, 1, 0,
        30'h103, 4'b1111, 32'h5566_7788, 0, 0, 0, 0, 0);
    // misaligned
    run(0, 2'b10, 0, 32'h102, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b01, 0, 0);
    run(1, 2'b01, 0, 32'h201, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10, 0, 0);
    run(0, 2'b11, 0, 32'h101, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b01, 0, 0);
    run(0, 2'b01, 1, 32'h105, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b01, 0, 0);
    // variable latency and bus errors
    run(0, 2'b10, 0, 32'h300, 0, 32'hCAFE_F00D, 5, 1, 0,
        30'hC0, 4'b0000, 32'h0, 0, 0, 0, 1, 32'hCAFE_F00D);
    run(0, 2'b10, 0, 32'h304, 0, 32'h1111_1111, 2, 1, 1,
        30'hC1, 4'b0000, 32'h0, 0, 1, 2'b11, 0, 0);
    run(1, 2'b10, 0, 32'h308, 32'h1122_3344, 0, 3, 0, 1,
        30'hC2, 4'b1111, 32'h1122_3344, 0, 1, 2'b11, 0, 0);
`ifdef MIPS_LSU_TIMEOUT_EN
    run(0, 2'b10, 0, 32'h500, 0, 0, 4, 0, 0,
        30'h140, 4'b0000, 32'h0, 0, 1, 2'b11, 0, 0);
`endif

    // ack/excpt outside WAIT are ignored
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_excpt = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_excpt = 1'b0;
    @(negedge clk);
    chk("stray_ack", {29'd0, lsu_done, lsu_excpt, mem_req}, 32'd0);

    // reset during WAIT
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'b10; lsu_addr = 32'h400;
    lsu_wdata = 32'h0;
    m.addr = 30'h100; m.wen = 4'b0000; m.din = 32'h0;
    mq.push_back(m);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mem_req_before_rst", 32'(mem_req), 32'd1);
    #1;
    rst_b = 1'b0; lsu_req = 1'b0;
    #1;
    chk("mem_req_async_drop", 32'(mem_req), 32'd0);
    chk("stall_in_rst", 32'(lsu_stall), 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    mem_ack = 1'b1; mem_data_out = 32'h9999_9999;
    @(negedge clk);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ignored", {29'd0, lsu_done, lsu_excpt, mem_req}, 32'd0);
    chk("rdata_cleared", lsu_rdata, 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mem_q_drained", mq.size(), 0);
    chk("ret_q_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
